// File: rtl/line_pkg.sv
//==============================================================================
// Module  : line_pkg
// Purpose : Shared line-command type, dispatcher states, screen window bounds
//           and the trivial-reject test (built only with LINE_DISPATCH_REJECT_EN).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package line_pkg;

  typedef struct packed {
    logic signed [12:0] sx;
    logic signed [12:0] sy;
    logic signed [12:0] ex;
    logic signed [12:0] ey;
    logic        [3:0]  color;
  } line_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } disp_state_t;

  localparam logic signed [12:0] SCREEN_X_MIN = -13'sd320;
  localparam logic signed [12:0] SCREEN_X_MAX =  13'sd319;
  localparam logic signed [12:0] SCREEN_Y_MIN = -13'sd240;
  localparam logic signed [12:0] SCREEN_Y_MAX =  13'sd240;

`ifdef LINE_DISPATCH_REJECT_EN
  // Both endpoints beyond the same edge: nothing of the line can be visible.
  // The y window is open at the bottom and closed at the top.
  function automatic logic line_offscreen(input line_cmd_t c);
    return ((c.sx <  SCREEN_X_MIN) && (c.ex <  SCREEN_X_MIN)) ||
           ((c.sx >  SCREEN_X_MAX) && (c.ex >  SCREEN_X_MAX)) ||
           ((c.sy >  SCREEN_Y_MAX) && (c.ey >  SCREEN_Y_MAX)) ||
           ((c.sy <= SCREEN_Y_MIN) && (c.ey <= SCREEN_Y_MIN));
  endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/line_cmd_fifo.sv
//==============================================================================
// Module  : line_cmd_fifo
// Purpose : Synchronous DEPTH-entry FIFO of line commands with level output.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module line_cmd_fifo
  import line_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  line_cmd_t                din,
  output line_cmd_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  line_cmd_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_level == (AW+1)'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign dout   = r_mem[r_rd_ptr];
  // A push is refused when full even if a pop frees a slot in the same cycle.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/line_dispatcher.sv
//==============================================================================
// Module  : line_dispatcher
// Purpose : Buffers line commands and sequences the rasterizer handshake one
//           line at a time; reports frame drain. Optional trivial reject of
//           off-screen lines with macro LINE_DISPATCH_REJECT_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module line_dispatcher
  import line_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [12:0]      cmd_start_x,
  input  logic signed [12:0]      cmd_start_y,
  input  logic signed [12:0]      cmd_end_x,
  input  logic signed [12:0]      cmd_end_y,
  input  logic [3:0]              cmd_color,
  input  logic                    frame_flush,
  input  logic                    rast_ready,
  input  logic                    rast_done,
  output logic                    rast_start,
  output logic [12:0]             rast_start_x,
  output logic [12:0]             rast_start_y,
  output logic [12:0]             rast_end_x,
  output logic [12:0]             rast_end_y,
  output logic [3:0]              rast_color,
  output logic                    busy,
  output logic                    frame_done,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [CNT_W-1:0]        lines_issued,
  output logic [CNT_W-1:0]        lines_rejected
);

  disp_state_t     r_state;
  disp_state_t     w_state_nxt;
  line_cmd_t       w_cmd_in;
  line_cmd_t       w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_issue;
  logic            w_reject_pop;
  logic            w_head_reject;
  logic            r_flush_pend;
  logic [CNT_W-1:0] r_lines_issued;

  assign w_cmd_in = '{sx: cmd_start_x, sy: cmd_start_y,
                      ex: cmd_end_x,   ey: cmd_end_y, color: cmd_color};

  line_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .pop   (w_pop),
    .din   (w_cmd_in),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  assign cmd_ready    = !w_full;
  assign rast_start_x = w_head.sx;
  assign rast_start_y = w_head.sy;
  assign rast_end_x   = w_head.ex;
  assign rast_end_y   = w_head.ey;
  assign rast_color   = w_head.color;

`ifdef LINE_DISPATCH_REJECT_EN
  logic [CNT_W-1:0] r_lines_rejected;

  assign w_head_reject = line_offscreen(w_head);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lines_rejected <= '0;
    end else if (w_reject_pop) begin
      r_lines_rejected <= r_lines_rejected + CNT_W'(1);
    end
  end

  assign lines_rejected = r_lines_rejected;
`else
  assign w_head_reject  = 1'b0;
  assign lines_rejected = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    rast_start   = 1'b0;
    w_pop        = 1'b0;
    w_issue      = 1'b0;
    w_reject_pop = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if (w_head_reject) begin
            w_pop        = 1'b1;
            w_reject_pop = 1'b1;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        rast_start = 1'b1;
        // The head pops only on capture, so rast_* data stays stable here.
        if (rast_ready) begin
          w_pop       = 1'b1;
          w_issue     = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (rast_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign frame_done = r_flush_pend && w_empty && (r_state == ST_IDLE);
  assign busy       = !w_empty || (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_pend   <= 1'b0;
      r_lines_issued <= '0;
    end else begin
      // A request arriving on the completion cycle is kept rather than lost.
      r_flush_pend <= frame_flush || (r_flush_pend && !frame_done);
      if (w_issue) begin
        r_lines_issued <= r_lines_issued + CNT_W'(1);
      end
    end
  end

  assign lines_issued = r_lines_issued;

endmodule

`default_nettype wire

// File: tb/tb_line_dispatcher.sv
//==============================================================================
// Module  : tb_line_dispatcher
// Purpose : Directed self-checking bench for line_dispatcher.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_line_dispatcher;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic signed [12:0] cmd_start_x, cmd_start_y, cmd_end_x, cmd_end_y;
  logic [3:0]         cmd_color;
  logic               frame_flush;
  logic               rast_ready;
  logic               rast_done;
  logic               rast_start;
  logic [12:0]        rast_start_x, rast_start_y, rast_end_x, rast_end_y;
  logic [3:0]         rast_color;
  logic               busy;
  logic               frame_done;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CNT_W-1:0]   lines_issued;
  logic [CNT_W-1:0]   lines_rejected;

  int n_checks = 0;
  int n_errors = 0;

  line_dispatcher #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_start_x    (cmd_start_x),
    .cmd_start_y    (cmd_start_y),
    .cmd_end_x      (cmd_end_x),
    .cmd_end_y      (cmd_end_y),
    .cmd_color      (cmd_color),
    .frame_flush    (frame_flush),
    .rast_ready     (rast_ready),
    .rast_done      (rast_done),
    .rast_start     (rast_start),
    .rast_start_x   (rast_start_x),
    .rast_start_y   (rast_start_y),
    .rast_end_x     (rast_end_x),
    .rast_end_y     (rast_end_y),
    .rast_color     (rast_color),
    .busy           (busy),
    .frame_done     (frame_done),
    .fifo_level     (fifo_level),
    .lines_issued   (lines_issued),
    .lines_rejected (lines_rejected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] c13(input int v);
    logic [12:0] t;
    t = v[12:0];
    return {19'b0, t};
  endfunction

  task automatic drive_cmd(input int sx, input int sy, input int ex, input int ey, input int col);
    cmd_valid   = 1'b1;
    cmd_start_x = sx[12:0];
    cmd_start_y = sy[12:0];
    cmd_end_x   = ex[12:0];
    cmd_end_y   = ey[12:0];
    cmd_color   = col[3:0];
  endtask

  // Wait (bounded) for a start request, check its start x, capture it and
  // return a one-cycle done in the first BUSY cycle.
  task automatic serve_line(input string tag, input int exp_sx);
    int n;
    n = 0;
    while (!rast_start && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_start_seen"}, {31'b0, rast_start}, 32'd1);
    check({tag, "_sx"}, {19'b0, rast_start_x}, c13(exp_sx));
    tick();
    rast_done = 1'b1;
    tick();
    rast_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_start_x = '0; cmd_start_y = '0; cmd_end_x = '0; cmd_end_y = '0;
    cmd_color = '0;
    frame_flush = 1'b0;
    rast_ready = 1'b1;
    rast_done = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_rast_start", {31'b0, rast_start}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_frame_done", {31'b0, frame_done}, 32'd0);
    check("rst_level", {28'b0, fifo_level}, 32'd0);
    check("rst_issued", {16'b0, lines_issued}, 32'd0);
    rst = 1'b0;

    // Single line: accept cycle, one IDLE cycle, then ISSUE.
    drive_cmd(0, 0, 10, 5, 3);
    tick();
    cmd_valid = 1'b0;
    check("t1_level", {28'b0, fifo_level}, 32'd1);
    check("t1_start_early", {31'b0, rast_start}, 32'd0);
    check("t1_busy_idle", {31'b0, busy}, 32'd1);
    tick();
    check("t1_start", {31'b0, rast_start}, 32'd1);
    check("t1_ex", {19'b0, rast_end_x}, 32'd10);
    check("t1_ey", {19'b0, rast_end_y}, 32'd5);
    check("t1_color", {28'b0, rast_color}, 32'd3);
    tick();
    check("t1_start_off", {31'b0, rast_start}, 32'd0);
    check("t1_popped", {28'b0, fifo_level}, 32'd0);
    check("t1_issued", {16'b0, lines_issued}, 32'd1);
    check("t1_busy", {31'b0, busy}, 32'd1);
    tick();
    rast_done = 1'b1;
    tick();
    rast_done = 1'b0;
    check("t1_idle_busy", {31'b0, busy}, 32'd0);

    // Fill with rasterizer stalled.
    rast_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_cmd(100 + i, 0, 0, 0, 1);
      tick();
    end
    check("t2_full_level", {28'b0, fifo_level}, 32'd8);
    check("t2_full_ready", {31'b0, cmd_ready}, 32'd0);
    drive_cmd(108, 0, 0, 0, 1);
    tick();
    check("t2_no_push", {28'b0, fifo_level}, 32'd8);
    check("t2_head", {19'b0, rast_start_x}, 32'd100);
    rast_ready = 1'b1;
    tick();
    rast_ready = 1'b0;
    check("t2_pop_level", {28'b0, fifo_level}, 32'd7);
    check("t2_ready_again", {31'b0, cmd_ready}, 32'd1);
    check("t2_next_head", {19'b0, rast_start_x}, 32'd101);
    check("t2_issued", {16'b0, lines_issued}, 32'd2);
    tick();
    cmd_valid = 1'b0;
    check("t2_ninth_in", {28'b0, fifo_level}, 32'd8);

    // Reset in BUSY with a full queue.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_level", {28'b0, fifo_level}, 32'd0);
    check("t6_start", {31'b0, rast_start}, 32'd0);
    check("t6_ready", {31'b0, cmd_ready}, 32'd1);
    check("t6_issued", {16'b0, lines_issued}, 32'd0);
    check("t6_rejected", {16'b0, lines_rejected}, 32'd0);
    check("t6_busy", {31'b0, busy}, 32'd0);
    rast_ready = 1'b1;

    // Three back-to-back lines, done four cycles after each capture.
    drive_cmd(11, 1, 1, 1, 2);
    tick();
    drive_cmd(22, 2, 2, 2, 4);
    tick();
    drive_cmd(33, 3, 3, 3, 6);
    for (int l = 0; l < 3; l++) begin
      check("t3_start", {31'b0, rast_start}, 32'd1);
      check("t3_sx", {19'b0, rast_start_x}, c13(11 * (l + 1)));
      tick();
      cmd_valid = 1'b0;
      check("t3_start_off", {31'b0, rast_start}, 32'd0);
      check("t3_issued", {16'b0, lines_issued}, 32'(l + 1));
      if (l == 0) check("t3_level_pushpop", {28'b0, fifo_level}, 32'd2);
      repeat (3) tick();
      rast_done = 1'b1;
      tick();
      rast_done = 1'b0;
      check("t3_gap_idle", {31'b0, rast_start}, 32'd0);
      if (l < 2) tick();
    end
    check("t3_total", {16'b0, lines_issued}, 32'd3);
    check("t3_busy_end", {31'b0, busy}, 32'd0);

    // Trivial reject.
    drive_cmd(-400, 0, -330, 50, 5);
    tick();
    drive_cmd(0, 0, 5, 5, 7);
    tick();
    cmd_valid = 1'b0;
`ifdef LINE_DISPATCH_REJECT_EN
    check("t4_level", {28'b0, fifo_level}, 32'd1);
    check("t4_rejected", {16'b0, lines_rejected}, 32'd1);
    check("t4_no_start", {31'b0, rast_start}, 32'd0);
    serve_line("t4_good", 0);
    check("t4_issued", {16'b0, lines_issued}, 32'd4);
    check("t4_rej_final", {16'b0, lines_rejected}, 32'd1);
`else
    check("t4_level", {28'b0, fifo_level}, 32'd2);
    check("t4_start_off", {31'b0, rast_start}, 32'd1);
    serve_line("t4_first", -400);
    serve_line("t4_second", 0);
    check("t4_issued", {16'b0, lines_issued}, 32'd5);
    check("t4_rej_final", {16'b0, lines_rejected}, 32'd0);
`endif
    check("t4_busy_end", {31'b0, busy}, 32'd0);

    // Flush with two lines pending; a second request merges.
    drive_cmd(44, 0, 1, 1, 1);
    tick();
    drive_cmd(55, 0, 1, 1, 1);
    frame_flush = 1'b1;
    tick();
    cmd_valid = 1'b0;
    frame_flush = 1'b0;
    check("t5_fd_issueA", {31'b0, frame_done}, 32'd0);
    check("t5_startA", {31'b0, rast_start}, 32'd1);
    tick();
    frame_flush = 1'b1;
    check("t5_fd_busyA", {31'b0, frame_done}, 32'd0);
    rast_done = 1'b1;
    tick();
    frame_flush = 1'b0;
    rast_done = 1'b0;
    check("t5_fd_idle", {31'b0, frame_done}, 32'd0);
    tick();
    check("t5_startB", {31'b0, rast_start}, 32'd1);
    check("t5_fd_issueB", {31'b0, frame_done}, 32'd0);
    tick();
    check("t5_fd_busyB", {31'b0, frame_done}, 32'd0);
    rast_done = 1'b1;
    tick();
    rast_done = 1'b0;
    check("t5_fd_pulse", {31'b0, frame_done}, 32'd1);
    tick();
    check("t5_fd_once", {31'b0, frame_done}, 32'd0);
    repeat (3) tick();
    check("t5_fd_quiet", {31'b0, frame_done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
